llc_dma_req_gen: RTL and testbench

LLC_DMA_REQ_GEN -- requirements
Module: llc_dma_req_gen

---
 rtl/llc_dma_req_gen_pkg.sv | 24 ++
 rtl/llc_dma_credit_cnt.sv | 39 +++
 rtl/llc_dma_req_gen.sv | 159 +++++++++++++++
 tb/tb_llc_dma_req_gen.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_dma_req_gen_pkg.sv
// Shared cache types for the LLC DMA request generator: line address / line data
// types, FSM state encoding and a small address helper.
package llc_dma_req_gen_pkg;

  localparam int unsigned LINE_ADDR_W = 32;
  localparam int unsigned LINE_W      = 64;

  typedef logic [LINE_ADDR_W-1:0] line_addr_t;
  typedef logic [LINE_W-1:0]      line_t;

  // FSM state encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] dma_state_t;
  localparam dma_state_t StIdle  = 3'd0;
  localparam dma_state_t StRd    = 3'd1;
  localparam dma_state_t StWr    = 3'd2;
  localparam dma_state_t StDrain = 3'd3;
  localparam dma_state_t StDone  = 3'd4;

  // Next line address; wraps from all-ones to zero.
  function automatic line_addr_t next_line(input line_addr_t addr);
    return addr + line_addr_t'(1);
  endfunction

endpackage

// File: rtl/llc_dma_credit_cnt.sv
// Outstanding-request counter: counts up on inc, down on dec, flags full at MAX_OUT.
module llc_dma_credit_cnt
  import llc_dma_req_gen_pkg::*;
#(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             dec_eff;

  // Next count; a decrement at zero is dropped so the counter never underflows.
  always_comb begin
    dec_eff = dec && (count_q != '0);
    count_d = count_q;
    case ({inc, dec_eff})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;
  assign full  = (count_q >= CNT_W'(MAX_OUT));

endmodule

// File: rtl/llc_dma_req_gen.sv
// LLC DMA request generator: splits a burst command into per-line LLC requests,
// passes read data through to the sink and write data from the source.
// Optional macro LLC_DMA_WR_ACK_EN: write bursts also wait for per-line acks.
module llc_dma_req_gen
  import llc_dma_req_gen_pkg::*;
#(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  line_addr_t       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             req_valid,
  input  logic             req_ready,
  output logic             req_write,
  output line_addr_t       req_addr,
  output line_t            req_line,
  output logic             req_last,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  line_t            wr_line,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  line_t            rsp_line,
  output logic             rd_valid,
  input  logic             rd_ready,
  output line_t            rd_line,
  output logic             busy,
  output logic             done
);

`ifdef LLC_DMA_WR_ACK_EN
  localparam bit WrAck = 1'b1;
`else
  localparam bit WrAck = 1'b0;
`endif

  localparam int unsigned CntW = 4;

  dma_state_t       state_q, state_d;
  line_addr_t       addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             write_q, write_d;

  logic [CntW-1:0]  out_count;
  logic             out_full;
  logic             req_fire, rsp_fire, cnt_inc;

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  // Reads always hold credits; writes only when acks are expected.
  assign cnt_inc  = req_fire && ((state_q == StRd) || WrAck);

  llc_dma_credit_cnt #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CntW)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .dec   (rsp_fire),
    .count (out_count),
    .full  (out_full)
  );

  // Handshake and data-path outputs decoded from the current state.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_line  = '0;
    req_addr  = addr_q;
    req_last  = ((state_q == StRd) || (state_q == StWr)) && (rem_q == LEN_W'(1));
    wr_ready  = 1'b0;
    rsp_ready = 1'b0;
    rd_valid  = 1'b0;
    rd_line   = rsp_line;
    case (state_q)
      StRd: begin
        req_valid = !out_full;
        rsp_ready = rd_ready;
        rd_valid  = rsp_valid;
      end
      StWr: begin
        // Joint handshake: the write source and the LLC move together.
        req_valid = wr_valid && (!WrAck || !out_full);
        wr_ready  = req_ready && (!WrAck || !out_full);
        req_write = 1'b1;
        req_line  = wr_line;
        rsp_ready = WrAck;
      end
      StDrain: begin
        if (write_q) begin
          rsp_ready = WrAck;
        end else begin
          rsp_ready = rd_ready;
          rd_valid  = rsp_valid;
        end
      end
      default: ;
    endcase
  end

  // Next-state, address and remaining-line bookkeeping.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    write_d = write_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          write_d = cmd_write;
          if (cmd_len == '0)  state_d = StDone;
          else if (cmd_write) state_d = StWr;
          else                state_d = StRd;
        end
      end
      StRd, StWr: begin
        if (req_fire) begin
          addr_d = next_line(addr_q);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ((state_q == StRd) || WrAck) ? StDrain : StDone;
          end
        end
      end
      StDrain: begin
        if (rsp_fire && (out_count == CntW'(1))) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      write_q <= write_d;
    end
  end

endmodule

// File: tb/tb_llc_dma_req_gen.sv
// Bench for llc_dma_req_gen: transaction-level model checked every cycle, directed
// scenarios with literal expectations, then randomized bursts.
module tb_llc_dma_req_gen;
  import llc_dma_req_gen_pkg::*;

  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned LEN_W   = 16;
`ifdef LLC_DMA_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  logic             clk, rst;
  logic             cmd_valid, cmd_ready, cmd_write;
  line_addr_t       cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             req_valid, req_ready, req_write, req_last;
  line_addr_t       req_addr;
  line_t            req_line;
  logic             wr_valid, wr_ready;
  line_t            wr_line;
  logic             rsp_valid, rsp_ready;
  line_t            rsp_line;
  logic             rd_valid, rd_ready;
  line_t            rd_line;
  logic             busy, done;

  llc_dma_req_gen #(
    .MAX_OUT (MAX_OUT),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_line  (req_line),
    .req_last  (req_last),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_line   (wr_line),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_line  (rsp_line),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_line   (rd_line),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Stimulus knobs (percent probabilities) and LLC responder control.
  int req_pct = 100, wr_pct = 100, rd_pct = 100, rsp_pct = 100, rsp_delay = 0;
  bit rsp_en = 1'b1;

  // Transaction-level model state.
  bit         m_active, m_write, m_done_due;
  line_addr_t m_base;
  int         m_len, m_sent, m_out;
  int         issue_q[$];

  // Logs used by the directed scenarios.
  line_addr_t fire_addr[$];
  bit         fire_last[$];
  int         fire_cyc[$];
  int         rsp_cyc[$];
  int         done_cyc[$];
  int         accept_cyc, rd_beats, done_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    fire_addr.delete(); fire_last.delete(); fire_cyc.delete();
    rsp_cyc.delete(); done_cyc.delete();
    rd_beats = 0;
  endtask

  // Per-cycle compare against the model, then advance the model.
  initial begin : monitor
    bit e_rd, e_wr, e_more, e_rv, e_wrr, e_rspr, e_rdv, req_f, rsp_f, nd;
    line_addr_t e_addr;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_active = 1'b0; m_done_due = 1'b0; m_out = 0;
        issue_q.delete();
      end else begin
        e_rd   = m_active && !m_write;
        e_wr   = m_active && m_write;
        e_more = m_active && (m_sent < m_len);
        e_rv   = e_rd ? (e_more && (m_out < MAX_OUT))
               : e_wr ? (e_more && wr_valid && (!WR_ACK || (m_out < MAX_OUT))) : 1'b0;
        e_wrr  = e_wr && e_more && req_ready && (!WR_ACK || (m_out < MAX_OUT));
        e_rspr = e_rd ? rd_ready : (e_wr && WR_ACK);
        e_rdv  = e_rd && rsp_valid;
        e_addr = line_addr_t'(m_base + line_addr_t'(m_sent));

        chk("cmd_ready", cmd_ready, !m_active && !m_done_due);
        chk("busy", busy, m_active || m_done_due);
        chk("done", done, m_done_due);
        chk("req_valid", req_valid, e_rv);
        chk("wr_ready", wr_ready, e_wrr);
        chk("rsp_ready", rsp_ready, e_rspr);
        chk("rd_valid", rd_valid, e_rdv);
        if (e_rv) begin
          chk("req_addr", req_addr, e_addr);
          chk("req_last", req_last, m_sent == m_len - 1);
          chk("req_write", req_write, m_write);
          if (m_write) chk("req_line", req_line, wr_line);
        end
        if (e_rdv) begin
          chk("rd_line", rd_line, rsp_line);
          if (rd_ready) rd_beats++;
        end
        if (done) begin
          done_cnt++;
          done_cyc.push_back(cyc);
        end

        req_f = e_rv && req_ready;
        rsp_f = rsp_valid && e_rspr;
        if (req_f) begin
          fire_addr.push_back(req_addr);
          fire_last.push_back(req_last);
          fire_cyc.push_back(cyc);
          m_sent++;
          if (!m_write || WR_ACK) begin
            m_out++;
            issue_q.push_back(cyc);
          end
        end
        if (rsp_f) begin
          m_out--;
          void'(issue_q.pop_front());
          rsp_cyc.push_back(cyc);
        end

        nd = 1'b0;
        if (!m_active && !m_done_due && cmd_valid) begin
          accept_cyc = cyc;
          if (cmd_len == '0) nd = 1'b1;
          else begin
            m_active = 1'b1; m_write = cmd_write; m_base = cmd_addr;
            m_len = int'(cmd_len); m_sent = 0;
          end
        end else if (m_active && (m_sent == m_len) && ((m_write && !WR_ACK) || (m_out == 0))) begin
          m_active = 1'b0;
          nd = 1'b1;
        end
        m_done_due = nd;
      end
      cyc++;
    end
  end

  // Random environment: LLC ready/responses, write source, read sink.
  initial begin : env
    req_ready = 1'b0; wr_valid = 1'b0; wr_line = '0; rd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_line = '0;
    forever begin
      @(posedge clk); #1;
      req_ready = ($urandom_range(99) < req_pct);
      wr_valid  = ($urandom_range(99) < wr_pct);
      wr_line   = {$urandom, $urandom};
      rd_ready  = ($urandom_range(99) < rd_pct);
      rsp_line  = {$urandom, $urandom};
      rsp_valid = 1'b0;
      if (rsp_en && (issue_q.size() > 0)) begin
        if ((cyc - issue_q[0] >= rsp_delay) && ($urandom_range(99) < rsp_pct)) rsp_valid = 1'b1;
      end
    end
  end

  task automatic issue(input bit w, input line_addr_t a, input int len);
    int t;
    @(posedge clk); #1;
    cmd_write = w; cmd_addr = a; cmd_len = LEN_W'(len); cmd_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && (t < 100)) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n, t;
    n = done_cnt;
    t = 0;
    while ((done_cnt == n) && (t < 3000)) begin
      @(negedge clk); #1;
      t++;
    end
    chk({name, "_done_seen"}, done_cnt > n, 1'b1);
  endtask

  initial begin : main
    int ack_end, n0, t;
    line_addr_t a;
    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req_addr", req_addr, '0);
    chk("rst_req_line", req_line, '0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // Read 0x100 x3, responses 2 cycles after each request.
    rsp_delay = 2;
    clear_logs();
    issue(1'b0, 32'h100, 3);
    wait_done("rd3");
    chk("rd3_fires", fire_addr.size(), 3);
    chk("rd3_a0", fire_addr[0], 32'h100);
    chk("rd3_a1", fire_addr[1], 32'h101);
    chk("rd3_a2", fire_addr[2], 32'h102);
    chk("rd3_last", {fire_last[0], fire_last[1], fire_last[2]}, 3'b001);
    chk("rd3_beats", rd_beats, 3);
    chk("rd3_done_cyc", done_cyc[0], rsp_cyc[2] + 1);
    rsp_delay = 0;

    // Read x8 with responses withheld: throttled at MAX_OUT.
    rsp_en = 1'b0;
    clear_logs();
    issue(1'b0, 32'h20, 8);
    repeat (12) @(negedge clk);
    #1;
    chk("thr_fires", fire_addr.size(), MAX_OUT);
    chk("thr_req_valid", req_valid, 1'b0);
    rsp_en = 1'b1;
    wait_done("thr");
    chk("thr_total", fire_addr.size(), 8);

    // Write 0x7 x2 with a gapped write source.
    wr_pct = 40;
    clear_logs();
    issue(1'b1, 32'h7, 2);
    wait_done("wr2");
    chk("wr2_fires", fire_addr.size(), 2);
    chk("wr2_a0", fire_addr[0], 32'h7);
    chk("wr2_a1", fire_addr[1], 32'h8);
    chk("wr2_rd_beats", rd_beats, 0);
    chk("wr2_acks", rsp_cyc.size(), WR_ACK ? 2 : 0);
    ack_end = (rsp_cyc.size() > 0) ? rsp_cyc[rsp_cyc.size()-1] : -1;
    chk("wr2_done_cyc", done_cyc[0], WR_ACK ? ack_end + 1 : fire_cyc[1] + 1);
    wr_pct = 100;

    // Zero-length command.
    clear_logs();
    issue(1'b0, 32'h55, 0);
    wait_done("len0");
    chk("len0_fires", fire_addr.size(), 0);
    chk("len0_done_cyc", done_cyc[0], accept_cyc + 1);

    // Address wrap.
    clear_logs();
    issue(1'b0, 32'hFFFF_FFFF, 2);
    wait_done("wrap");
    chk("wrap_a0", fire_addr[0], 32'hFFFF_FFFF);
    chk("wrap_a1", fire_addr[1], 32'h0);

    // Reset in the middle of a read with two lines outstanding.
    rsp_en = 1'b0;
    clear_logs();
    issue(1'b0, 32'h300, 8);
    t = 0;
    while ((fire_addr.size() < 2) && (t < 100)) begin
      @(negedge clk); #1;
      t++;
    end
    req_pct = 0;
    chk("rstmid_fires", fire_addr.size(), 2);
    n0 = done_cnt;
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rstmid_cmd_ready", cmd_ready, 1'b1);
    chk("rstmid_req_valid", req_valid, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", done, 1'b0);
    chk("rstmid_req_addr", req_addr, '0);
    chk("rstmid_req_last", req_last, 1'b0);
    chk("rstmid_rd_valid", rd_valid, 1'b0);
    chk("rstmid_rsp_ready", rsp_ready, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    rsp_en = 1'b1; req_pct = 100;
    repeat (5) @(negedge clk);
    #1;
    chk("rstmid_no_done", done_cnt, n0);
    chk("rstmid_idle", cmd_ready, 1'b1);

    // Randomized bursts.
    for (int i = 0; i < 40; i++) begin
      req_pct   = $urandom_range(100, 30);
      wr_pct    = $urandom_range(100, 30);
      rd_pct    = $urandom_range(100, 30);
      rsp_pct   = $urandom_range(100, 30);
      rsp_delay = $urandom_range(4);
      a = ($urandom_range(3) == 0) ? (32'hFFFF_FFF8 | line_addr_t'($urandom_range(7)))
                                   : line_addr_t'($urandom);
      issue($urandom_range(1) == 1, a, $urandom_range(12));
      wait_done("rand");
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
